// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and grant-FSM state type for the VGA timing slice.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef enum logic {
    IDLE,
    GRANT
  } grant_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one display axis; wrap flags the enabled terminal-count edge.
module vga_axis_counter #(
  parameter int unsigned TOTAL = 800
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [9:0] count,
  output logic       wrap
);

  assign wrap = en && (count == 10'(TOTAL - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 10'd1;
    end
  end

endmodule

// File: rtl/vga_timing_controller.sv
// VGA 640x480@60 timing generator with vblank-only update grant.
// Optional frame_count output enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_controller
  import vga_timing_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       upd_req,
  output logic       upd_grant,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  logic         h_wrap;
  logic         v_wrap;
  logic [9:0]   h_next;
  logic [9:0]   v_next;
  logic         close;
  grant_state_t state;
  grant_state_t state_next;

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_counter (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en),
    .count (h_count),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_counter (
    .clk   (clk),
    .reset (reset),
    .en    (h_wrap),
    .count (v_count),
    .wrap  (v_wrap)
  );

  // Mirror the counters' next values so the sync decode lands on the same edge.
  always_comb begin
    h_next = h_count;
    v_next = v_count;
    if (pix_en) begin
      h_next = h_wrap ? '0 : h_count + 10'd1;
      if (h_wrap) begin
        v_next = v_wrap ? '0 : v_count + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= v_wrap;
      if (pix_en) begin
        hsync    <= !((h_next >= 10'(H_SYNC_START)) && (h_next < 10'(H_SYNC_END)));
        vsync    <= !((v_next >= 10'(V_SYNC_START)) && (v_next < 10'(V_SYNC_END)));
        video_on <= (h_next < 10'(H_ACTIVE)) && (v_next < 10'(V_ACTIVE));
      end
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
    end else if (v_wrap) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`endif

  // Counters are about to step onto (0, V_TOTAL-1): the grant must be gone by then.
  assign close = h_wrap && (v_count == 10'(V_TOTAL - 2));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (upd_req && (v_count >= 10'(V_ACTIVE)) && (v_count < 10'(V_TOTAL - 1)) && !close) begin
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (!upd_req || close) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign upd_grant = (state == GRANT);

endmodule
